// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store unit behind the 64-bit ALU.
// Takes the ALU result as an effective address and runs one access at a time
// on a req/gnt/rvalid data-memory port. Load data comes back sign- or
// zero-extended. A misaligned access completes at once with a flag and does
// not touch memory.
// Optional build macro: LSU_PERF_CNT_EN adds the 32-bit perf_stall_cnt output.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a new access; captures the request
// REQ    | mem_req high, address/data/strobes held until mem_gnt
// WAIT   | load granted, waiting for mem_rvalid
// RESP   | one-cycle resp_valid pulse back to the pipeline
module lsu_mem_stage #(
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_misaligned,
`ifdef LSU_PERF_CNT_EN
    output logic [31:0]       perf_stall_cnt,
`endif
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [2:0]  r_off;

    logic              w_misaligned;
    logic [STRB_W-1:0] w_lane_strb;
    logic [DATA_W-1:0] w_lane_wdata;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_load_ext;

    // Alignment check and store lane placement from the incoming request
    always_comb begin
        w_misaligned = 1'b0;
        w_lane_strb  = '0;
        case (req_size)
            2'b00: begin
                w_misaligned = 1'b0;
                w_lane_strb  = 8'b0000_0001 << req_addr[2:0];
            end
            2'b01: begin
                w_misaligned = req_addr[0];
                w_lane_strb  = 8'b0000_0011 << req_addr[2:0];
            end
            2'b10: begin
                w_misaligned = |req_addr[1:0];
                w_lane_strb  = 8'b0000_1111 << req_addr[2:0];
            end
            default: begin
                w_misaligned = |req_addr[2:0];
                w_lane_strb  = 8'hFF;
            end
        endcase
        w_lane_wdata = req_wdata << {req_addr[2:0], 3'b000};
    end

    // Right-justify the addressed bytes and extend to the access size
    always_comb begin
        w_shifted  = mem_rdata >> {r_off, 3'b000};
        w_load_ext = w_shifted;
        case (r_size)
            2'b00: w_load_ext = r_unsigned ? {{(DATA_W-8){1'b0}}, w_shifted[7:0]}
                                           : {{(DATA_W-8){w_shifted[7]}}, w_shifted[7:0]};
            2'b01: w_load_ext = r_unsigned ? {{(DATA_W-16){1'b0}}, w_shifted[15:0]}
                                           : {{(DATA_W-16){w_shifted[15]}}, w_shifted[15:0]};
            2'b10: w_load_ext = r_unsigned ? {{(DATA_W-32){1'b0}}, w_shifted[31:0]}
                                           : {{(DATA_W-32){w_shifted[31]}}, w_shifted[31:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    // Access sequencer with all handshake outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_we            <= 1'b0;
            r_size          <= 2'b00;
            r_unsigned      <= 1'b0;
            r_off           <= 3'b000;
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_wstrb       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_off      <= req_addr[2:0];
                        req_ready  <= 1'b0;
                        if (w_misaligned) begin
                            r_state         <= S_RESP;
                            resp_valid      <= 1'b1;
                            resp_misaligned <= 1'b1;
                            resp_rdata      <= '0;
                        end else begin
                            r_state   <= S_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[DATA_W-1:3], 3'b000};
                            mem_wdata <= req_we ? w_lane_wdata : '0;
                            mem_wstrb <= req_we ? w_lane_strb : '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (r_we) begin
                            r_state    <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_state    <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= w_load_ext;
                    end
                end
                S_RESP: begin
                    r_state         <= S_IDLE;
                    resp_valid      <= 1'b0;
                    resp_misaligned <= 1'b0;
                    resp_rdata      <= '0;
                    req_ready       <= 1'b1;
                end
                default: begin
                    r_state   <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef LSU_PERF_CNT_EN
    // Saturating count of cycles stalled on gnt or rvalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
        end else if (((r_state == S_REQ) && !mem_gnt) ||
                     ((r_state == S_WAIT) && !mem_rvalid)) begin
            if (perf_stall_cnt != 32'hFFFF_FFFF) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: cycle-exact stores, loads, misaligned
// accesses, gnt/rvalid stalls and reset in the middle of a load.
module tb_lsu_mem_stage;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_resp   = 0;

    lsu_mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
`ifdef LSU_PERF_CNT_EN
        .perf_stall_cnt  (perf_stall_cnt),
`endif
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_gnt         (mem_gnt),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (resp_valid) n_resp <= n_resp + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle; returns at the negedge of cycle 1
    task automatic start(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(negedge clk);
        req_valid    = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [1:0] size, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [63:0] exp_wdata,
                            input logic [7:0] exp_strb);
        start(1'b1, size, 1'b0, addr, wdata);
        chk({tag, "_req"},   {63'd0, mem_req}, 64'd1);
        chk({tag, "_we"},    {63'd0, mem_we}, 64'd1);
        chk({tag, "_addr"},  mem_addr, addr & ~64'h7);
        chk({tag, "_wdata"}, mem_wdata, exp_wdata);
        chk({tag, "_wstrb"}, {56'd0, mem_wstrb}, {56'd0, exp_strb});
        chk({tag, "_c1_valid"}, {63'd0, resp_valid}, 64'd0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk({tag, "_c2_valid"}, {63'd0, resp_valid}, 64'd1);
        chk({tag, "_rdata"},    resp_rdata, 64'd0);
        chk({tag, "_misal"},    {63'd0, resp_misaligned}, 64'd0);
        chk({tag, "_c2_req"},   {63'd0, mem_req}, 64'd0);
        @(negedge clk);
        chk({tag, "_c3_valid"}, {63'd0, resp_valid}, 64'd0);
        chk({tag, "_ready"},    {63'd0, req_ready}, 64'd1);
    endtask

    task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                           input logic [63:0] addr, input logic [63:0] rdata,
                           input logic [63:0] exp);
        start(1'b0, size, uns, addr, 64'hFFFF_FFFF_FFFF_FFFF);
        chk({tag, "_req"},   {63'd0, mem_req}, 64'd1);
        chk({tag, "_we"},    {63'd0, mem_we}, 64'd0);
        chk({tag, "_wstrb"}, {56'd0, mem_wstrb}, 64'd0);
        chk({tag, "_addr"},  mem_addr, addr & ~64'h7);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk({tag, "_c2_req"},   {63'd0, mem_req}, 64'd0);
        chk({tag, "_c2_valid"}, {63'd0, resp_valid}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = 64'h0;
        chk({tag, "_c3_valid"}, {63'd0, resp_valid}, 64'd1);
        chk({tag, "_rdata"},    resp_rdata, exp);
        @(negedge clk);
        chk({tag, "_c4_valid"}, {63'd0, resp_valid}, 64'd0);
    endtask

    task automatic do_misaligned(input string tag, input logic we, input logic [1:0] size,
                                 input logic [63:0] addr);
        start(we, size, 1'b0, addr, 64'h1234);
        chk({tag, "_valid"}, {63'd0, resp_valid}, 64'd1);
        chk({tag, "_misal"}, {63'd0, resp_misaligned}, 64'd1);
        chk({tag, "_rdata"}, resp_rdata, 64'd0);
        chk({tag, "_req1"},  {63'd0, mem_req}, 64'd0);
        chk({tag, "_ready"}, {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        chk({tag, "_c2_valid"}, {63'd0, resp_valid}, 64'd0);
        chk({tag, "_c2_misal"}, {63'd0, resp_misaligned}, 64'd0);
        chk({tag, "_req2"},     {63'd0, mem_req}, 64'd0);
        chk({tag, "_c2_ready"}, {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);

        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_misal", {63'd0, resp_misaligned}, 64'd0);
        chk("rst_mreq",  {63'd0, mem_req}, 64'd0);
        chk("rst_mwe",   {63'd0, mem_we}, 64'd0);
        chk("rst_maddr", mem_addr, 64'd0);
        chk("rst_mwd",   mem_wdata, 64'd0);
        chk("rst_mstrb", {56'd0, mem_wstrb}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Stray gnt/rvalid while idle must do nothing
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hFFFF;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h0;
        chk("idle_ign_valid", {63'd0, resp_valid}, 64'd0);
        chk("idle_ign_req",   {63'd0, mem_req}, 64'd0);
        chk("idle_ign_ready", {63'd0, req_ready}, 64'd1);

        do_store("sd", 2'b11, 64'h1000, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 8'hFF);
        do_store("sh", 2'b01, 64'h3006, 64'h0000_0000_0000_ABCD, 64'hABCD_0000_0000_0000, 8'hC0);
        do_store("sb", 2'b00, 64'h1005, 64'h0000_0000_0000_005A, 64'h0000_5A00_0000_0000, 8'h20);
        do_store("sw", 2'b10, 64'h2004, 64'h0000_0000_89AB_CDEF, 64'h89AB_CDEF_0000_0000, 8'hF0);

        do_load("lb",  2'b00, 1'b0, 64'h2003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lbu", 2'b00, 1'b1, 64'h2003, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
        do_load("lh",  2'b01, 1'b0, 64'h7002, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);
        do_load("lhu", 2'b01, 1'b1, 64'h7002, 64'h0000_0000_8001_0000, 64'h0000_0000_0000_8001);
        do_load("lw",  2'b10, 1'b0, 64'h6004, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001);
        do_load("lwu", 2'b10, 1'b1, 64'h6004, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001);

        do_misaligned("mis_lw", 1'b0, 2'b10, 64'h4002);
        do_misaligned("mis_sd", 1'b1, 2'b11, 64'h9004);
        do_misaligned("mis_lh", 1'b0, 2'b01, 64'h7001);

        // LD with gnt low for three REQ cycles, rvalid two cycles after gnt
        r0 = n_resp;
        start(1'b0, 2'b11, 1'b0, 64'h5008, 64'h0);
        for (int i = 0; i < 4; i++) begin
            chk("stall_req",  {63'd0, mem_req}, 64'd1);
            chk("stall_addr", mem_addr, 64'h5008);
            if (i == 3) mem_gnt = 1'b1;
            @(negedge clk);
        end
        mem_gnt = 1'b0;
        chk("stall_wait_req",   {63'd0, mem_req}, 64'd0);
        chk("stall_wait_valid", {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 64'h0;
        chk("stall_valid", {63'd0, resp_valid}, 64'd1);
        chk("stall_rdata", resp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
        repeat (2) @(negedge clk);
        chk("stall_once", 64'(n_resp - r0), 64'd1);
`ifdef LSU_PERF_CNT_EN
        chk("perf_cnt", {32'd0, perf_stall_cnt}, 64'd4);
`endif

        // Reset while waiting for load data; a later rvalid must be dropped
        r0 = n_resp;
        start(1'b0, 2'b11, 1'b0, 64'h8000, 64'h0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rstmid_req",   {63'd0, mem_req}, 64'd0);
        chk("rstmid_ready", {63'd0, req_ready}, 64'd1);
`ifdef LSU_PERF_CNT_EN
        chk("rstmid_perf",  {32'd0, perf_stall_cnt}, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 64'h55;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 64'h0;
        repeat (3) @(negedge clk);
        chk("rstmid_valid",  {63'd0, resp_valid}, 64'd0);
        chk("rstmid_ready2", {63'd0, req_ready}, 64'd1);
        chk("rstmid_noresp", 64'(n_resp - r0), 64'd0);

        // Normal operation resumes after the abort
        do_store("post_sd", 2'b11, 64'hA000, 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the 64-bit ALU; consumes the ALU result as the effective address for LB/LH/LW/LD/LBU/LHU/LWU/SB/SH/SW/SD.
- Drives a single-outstanding, 64-bit-wide data-memory port with a req/gnt/rvalid handshake.
- Returns sign/zero-extended load data to writeback.
- Detects misaligned accesses and reports them without touching memory.

Parameters:
- DATA_W, 64, data and address width; only 64 is supported.
- STRB_W, 8, byte-strobe width (DATA_W/8).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  access request from the execute stage.
- req_ready  out  1  LSU can accept a request (IDLE only).
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword.
- req_unsigned  in  1  zero-extend load (LBU/LHU/LWU); ignored for stores and dword.
- req_addr  in  64  effective address (ALU result).
- req_wdata  in  64  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  64  extended load data; 0 for stores and misaligned accesses.
- resp_misaligned  out  1  qualified by resp_valid.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  64  {req_addr[63:3],3'b000}.
- mem_wdata  out  64  store data shifted to byte lane.
- mem_wstrb  out  8  byte strobes; 0 for loads.
- mem_gnt  in  1  memory accepted request this cycle.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  64  aligned 64-bit read data.

Behaviour:
- Reset values (async, immediate): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_misaligned=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
- State IDLE:
  - req_ready=1.
  - On req_valid, capture we/size/unsigned/addr/wdata.
  - If misaligned, go to RESP with the misaligned flag set. Misaligned means: half with addr[0]≠0; word with addr[1:0]≠0; dword with addr[2:0]≠0.
  - Otherwise go to REQ.
  - mem_rvalid is ignored in IDLE.
- State REQ:
  - mem_req=1; mem_we/mem_addr/mem_wdata/mem_wstrb are registered and held stable until mem_gnt.
  - Store: on gnt go to RESP.
  - Load: on gnt go to WAIT.
- State WAIT:
  - mem_req=0.
  - On mem_rvalid, go to RESP and register resp_rdata.
  - To form resp_rdata, shift mem_rdata right by addr[2:0]*8, then sign- or zero-extend to the access size.
- State RESP:
  - resp_valid=1 for exactly one cycle, then go to IDLE.
  - req_ready=0.
- Store lanes:
  - Let off=addr[2:0]. mem_wdata = req_wdata << (off*8).
  - mem_wstrb: byte=8'b1<<off; half=8'b11<<off; word=8'hF<<off; dword=8'hFF.
- Latency (request cycle = 0, gnt in first REQ cycle):
  - Store: resp_valid at cycle 2.
  - Load with rvalid one cycle after gnt: resp_valid at cycle 3.
  - Misaligned: resp_valid at cycle 1.
- Stalls:
  - gnt low extends REQ indefinitely.
  - rvalid low extends WAIT indefinitely.
  - No timeout.
- mem_gnt or mem_rvalid outside REQ/WAIT respectively is ignored.
- Only one access is in flight; req_valid is ignored while req_ready=0.
- Reset mid-operation: mem_req drops immediately; any rvalid arriving later is discarded; no resp_valid is produced for the aborted access.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- Defined:
  - Adds output port perf_stall_cnt (32 bits).
  - Counts cycles spent in REQ with mem_gnt=0, plus cycles spent in WAIT with mem_rvalid=0.
  - Saturates at 32'hFFFFFFFF; reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- SD addr=0x1000, wdata=0x1122334455667788, gnt immediate -> mem_addr=0x1000, mem_wstrb=0xFF, mem_wdata unchanged, resp_valid at cycle 2, resp_rdata=0.
- LB addr=0x2003, mem_rdata=0x00000000_80000000 (byte3=0x80), rvalid one cycle after gnt -> resp_rdata=0xFFFFFFFFFFFFFF80. Same access as LBU -> 0x0000000000000080.
- SH addr=0x3006, wdata=0xABCD -> mem_wstrb=0xC0, mem_wdata=0xABCD000000000000, mem_addr=0x3000.
- LW addr=0x4002 -> resp_misaligned=1 at cycle 1, mem_req never asserted, resp_rdata=0.
- LD with gnt held low 3 cycles, then rvalid 2 cycles after gnt -> mem_req/mem_addr stable for 4 cycles, resp_valid once. With LSU_PERF_CNT_EN, perf_stall_cnt=4.
- Assert rst during WAIT, then pulse mem_rvalid after release -> state IDLE, req_ready=1, no resp_valid pulse.
